// File: rtl/hb_softstart_if.sv
`default_nettype none
// ============================================================================
// Module      : hb_softstart_if
// Description : Control/status bundle between a half-bridge soft-start
//               controller and its surroundings (run request, fault, period
//               tick, comparator, ramp configuration, bridge control outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface hb_softstart_if;
    logic       en;
    logic       fault;
    logic       period_start;
    logic       cmp;
    logic [7:0] iref_target;
    logic [3:0] ramp_step;
    logic [7:0] ramp_div;
    logic [7:0] precharge_periods;
    logic [7:0] cooldown_periods;
    logic [2:0] retry_limit;
    logic       bridge_en;
    logic       low_only;
    logic [7:0] iref;
    logic [2:0] state;
    logic       fault_latched;
    logic [2:0] retries;

    // Supervisor side: issues requests/configuration, observes the bridge.
    modport master (
        output en, fault, period_start, cmp, iref_target, ramp_step, ramp_div,
               precharge_periods, cooldown_periods, retry_limit,
        input  bridge_en, low_only, iref, state, fault_latched, retries
    );

    // Controller side.
    modport slave (
        input  en, fault, period_start, cmp, iref_target, ramp_step, ramp_div,
               precharge_periods, cooldown_periods, retry_limit,
        output bridge_en, low_only, iref, state, fault_latched, retries
    );
endinterface
`default_nettype wire

// File: rtl/hb_softstart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hb_softstart_ctrl
// Description : Half-bridge soft-start sequencer: bootstrap precharge, stepped
//               peak-current reference ramp, overcurrent/fault trip with
//               cooldown, bounded auto-retry and lockout. All outputs are
//               registered from the next-state logic.
// Revision    : 1.0 - initial release
// ============================================================================
module hb_softstart_ctrl #(
    parameter int OC_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    hb_softstart_if.slave bus
);

    localparam logic [7:0] C_OC_LIMIT = 8'(OC_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRECHARGE = 3'd1,
        S_RAMP      = 3'd2,
        S_RUN       = 3'd3,
        S_COOLDOWN  = 3'd4,
        S_LOCKOUT   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_cnt_q, pc_cnt_d;       // precharge periods elapsed
    logic [7:0] step_cnt_q, step_cnt_d;   // periods since last ramp step
    logic [7:0] oc_cnt_q, oc_cnt_d;       // consecutive overcurrent periods
    logic [7:0] cd_cnt_q, cd_cnt_d;       // cooldown periods elapsed
    logic [2:0] retries_q, retries_d;
    logic [7:0] iref_q, iref_d;
    logic       bridge_en_q, bridge_en_d;
    logic       low_only_q, low_only_d;
    logic       fault_latched_q, fault_latched_d;

    // Configuration captured when leaving IDLE so a live change cannot
    // disturb a start-up already in progress.
    logic [7:0] cfg_target_q, cfg_target_d;
    logic [3:0] cfg_step_q, cfg_step_d;
    logic [7:0] cfg_div_q, cfg_div_d;
    logic [7:0] cfg_pre_q, cfg_pre_d;
    logic [7:0] cfg_cool_q, cfg_cool_d;
    logic [2:0] cfg_retry_q, cfg_retry_d;

    logic       trip;
    logic       cd_done;
    logic [8:0] ramp_sum;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pc_cnt_d    = pc_cnt_q;
        step_cnt_d  = step_cnt_q;
        oc_cnt_d    = oc_cnt_q;
        cd_cnt_d    = cd_cnt_q;
        retries_d   = retries_q;
        iref_d      = iref_q;
        cfg_target_d = cfg_target_q;
        cfg_step_d  = cfg_step_q;
        cfg_div_d   = cfg_div_q;
        cfg_pre_d   = cfg_pre_q;
        cfg_cool_d  = cfg_cool_q;
        cfg_retry_d = cfg_retry_q;
        trip        = 1'b0;
        cd_done     = 1'b0;
        // Nine bits so the sum can exceed 255 and be clamped instead of wrapping.
        ramp_sum    = {1'b0, iref_q} + {5'd0, cfg_step_q};

        case (state_q)
            S_IDLE: begin
                if (bus.en && !bus.fault) begin
                    state_d      = S_PRECHARGE;
                    cfg_target_d = bus.iref_target;
                    cfg_step_d   = bus.ramp_step;
                    cfg_div_d    = bus.ramp_div;
                    cfg_pre_d    = bus.precharge_periods;
                    cfg_cool_d   = bus.cooldown_periods;
                    cfg_retry_d  = bus.retry_limit;
                end
            end
            S_PRECHARGE: begin
                if (bus.fault) begin
                    trip = 1'b1;
                end else if (cfg_pre_q == 8'd0) begin
                    state_d = S_RAMP;
                end else if (bus.period_start) begin
                    pc_cnt_d = pc_cnt_q + 8'd1;
                    if (pc_cnt_d == cfg_pre_q) begin
                        state_d = S_RAMP;
                    end
                end
            end
            S_RAMP, S_RUN: begin
                if (bus.period_start) begin
                    if (bus.cmp) begin
                        oc_cnt_d = oc_cnt_q + 8'd1;
                        if (oc_cnt_d == C_OC_LIMIT) begin
                            trip = 1'b1;
                        end
                    end else begin
                        oc_cnt_d = 8'd0;
                    end
                end
                if (bus.fault) begin
                    trip = 1'b1;
                end
                if (state_q == S_RAMP) begin
                    // A zero step would never converge, so it jumps straight to target.
                    if ((iref_q == cfg_target_q) || (cfg_step_q == 4'd0)) begin
                        state_d = S_RUN;
                    end else if (bus.period_start) begin
                        if (step_cnt_q == cfg_div_q) begin
                            step_cnt_d = 8'd0;
                            iref_d = (ramp_sum > {1'b0, cfg_target_q}) ? cfg_target_q
                                                                         : ramp_sum[7:0];
                        end else begin
                            step_cnt_d = step_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_COOLDOWN: begin
                // The counter parks at the terminal value so a pending fault
                // keeps the decision armed until it clears.
                if (cd_cnt_q == cfg_cool_q) begin
                    cd_done = 1'b1;
                end else if (bus.period_start) begin
                    cd_cnt_d = cd_cnt_q + 8'd1;
                    cd_done  = (cd_cnt_d == cfg_cool_q);
                end
                if (cd_done) begin
                    if (retries_q > cfg_retry_q) begin
                        state_d = S_LOCKOUT;
                    end else if (!bus.fault) begin
                        state_d = S_PRECHARGE;
                    end
                end
            end
            S_LOCKOUT: begin
                state_d = S_LOCKOUT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (trip) begin
            state_d   = S_COOLDOWN;
            retries_d = (retries_q == 3'd7) ? 3'd7 : retries_q + 3'd1;
        end

        // Dropping the run request overrides everything, including a trip.
        if (!bus.en) begin
            state_d = S_IDLE;
        end

        // Every state starts its own counting from zero.
        if (state_d != state_q) begin
            pc_cnt_d   = 8'd0;
            step_cnt_d = 8'd0;
            oc_cnt_d   = 8'd0;
            cd_cnt_d   = 8'd0;
        end

        if (state_d == S_IDLE) begin
            retries_d = 3'd0;
        end

        bridge_en_d     = (state_d == S_RAMP) || (state_d == S_RUN);
        low_only_d      = (state_d == S_PRECHARGE);
        fault_latched_d = (state_d == S_LOCKOUT);
        if (state_d == S_RUN) begin
            iref_d = cfg_target_d;
        end else if (state_d != S_RAMP) begin
            iref_d = 8'd0;
        end
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pc_cnt_q        <= 8'd0;
            step_cnt_q      <= 8'd0;
            oc_cnt_q        <= 8'd0;
            cd_cnt_q        <= 8'd0;
            retries_q       <= 3'd0;
            iref_q          <= 8'd0;
            bridge_en_q     <= 1'b0;
            low_only_q      <= 1'b0;
            fault_latched_q <= 1'b0;
            cfg_target_q    <= 8'd0;
            cfg_step_q      <= 4'd0;
            cfg_div_q       <= 8'd0;
            cfg_pre_q       <= 8'd0;
            cfg_cool_q      <= 8'd0;
            cfg_retry_q     <= 3'd0;
        end else begin
            state_q         <= state_d;
            pc_cnt_q        <= pc_cnt_d;
            step_cnt_q      <= step_cnt_d;
            oc_cnt_q        <= oc_cnt_d;
            cd_cnt_q        <= cd_cnt_d;
            retries_q       <= retries_d;
            iref_q          <= iref_d;
            bridge_en_q     <= bridge_en_d;
            low_only_q      <= low_only_d;
            fault_latched_q <= fault_latched_d;
            cfg_target_q    <= cfg_target_d;
            cfg_step_q      <= cfg_step_d;
            cfg_div_q       <= cfg_div_d;
            cfg_pre_q       <= cfg_pre_d;
            cfg_cool_q      <= cfg_cool_d;
            cfg_retry_q     <= cfg_retry_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.bridge_en     = bridge_en_q;
    assign bus.low_only      = low_only_q;
    assign bus.iref          = iref_q;
    assign bus.fault_latched = fault_latched_q;
    assign bus.retries       = retries_q;

endmodule
`default_nettype wire

// File: tb/tb_hb_softstart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hb_softstart_ctrl
// Description : Directed self-checking bench for hb_softstart_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hb_softstart_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   r_checks   = 0;
    int   r_failures = 0;

    hb_softstart_if bus ();

    hb_softstart_ctrl #(.OC_LIMIT(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int be, input int lo,
                           input int ir);
        chk({tag, ".state"}, 32'(bus.state), st);
        chk({tag, ".bridge_en"}, 32'(bus.bridge_en), be);
        chk({tag, ".low_only"}, 32'(bus.low_only), lo);
        chk({tag, ".iref"}, 32'(bus.iref), ir);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One switching period: an idle clock, then the period_start pulse.
    task automatic period();
        bus.period_start = 1'b0;
        tick();
        bus.period_start = 1'b1;
        tick();
        bus.period_start = 1'b0;
    endtask

    task automatic set_cfg(input int tgt, input int stp, input int dv, input int pre,
                           input int cool, input int lim);
        bus.iref_target       = 8'(tgt);
        bus.ramp_step         = 4'(stp);
        bus.ramp_div          = 8'(dv);
        bus.precharge_periods = 8'(pre);
        bus.cooldown_periods  = 8'(cool);
        bus.retry_limit       = 3'(lim);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.fault = 1'b0;
        bus.period_start = 1'b0;
        bus.cmp = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.fault_latched", 32'(bus.fault_latched), 0);
        chk("reset.retries", 32'(bus.retries), 0);
        rst = 1'b0;

        // Nominal start: 4 precharge periods, ramp 10..100 every 2 periods.
        set_cfg(100, 10, 1, 4, 2, 1);
        bus.en = 1'b1;
        tick();
        chk_out("pre_entry", 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) period();
        chk_out("pre_3", 1, 0, 1, 0);
        period();
        chk_out("ramp_entry", 2, 1, 0, 0);
        period();
        chk("ramp_half", 32'(bus.iref), 0);
        period();
        chk("ramp_k1", 32'(bus.iref), 10);
        for (int k = 2; k <= 10; k++) begin
            period();
            period();
            chk($sformatf("ramp_k%0d", k), 32'(bus.iref), 10 * k);
        end
        chk("ramp_last_state", 32'(bus.state), 2);
        tick();
        chk_out("run_entry", 3, 1, 0, 100);

        // Overcurrent: two hits, a clear, then three consecutive hits trip.
        bus.cmp = 1'b1;
        period();
        period();
        chk("oc_two", 32'(bus.state), 3);
        bus.cmp = 1'b0;
        period();
        chk("oc_clear", 32'(bus.state), 3);
        bus.cmp = 1'b1;
        period();
        period();
        chk("oc_two_again", 32'(bus.state), 3);
        period();
        bus.cmp = 1'b0;
        chk_out("oc_trip", 4, 0, 0, 0);
        chk("oc_trip.retries", 32'(bus.retries), 1);

        // Cooldown of 2 periods, retries 1 <= limit 1 -> precharge again.
        period();
        chk("cool_1", 32'(bus.state), 4);
        period();
        chk_out("cool_done", 1, 0, 1, 0);
        chk("cool_done.retries", 32'(bus.retries), 1);
        for (int i = 0; i < 4; i++) period();
        chk("retry_ramp", 32'(bus.state), 2);
        for (int i = 0; i < 20; i++) period();
        tick();
        chk_out("retry_run", 3, 1, 0, 100);

        // External fault trips again; retries 2 > 1 -> lockout after cooldown.
        bus.fault = 1'b1;
        tick();
        bus.fault = 1'b0;
        chk("fault_trip.state", 32'(bus.state), 4);
        chk("fault_trip.retries", 32'(bus.retries), 2);
        period();
        period();
        chk_out("lockout", 5, 0, 0, 0);
        chk("lockout.fault_latched", 32'(bus.fault_latched), 1);
        tick();
        chk("lockout_hold", 32'(bus.state), 5);
        bus.en = 1'b0;
        tick();
        chk_out("lockout_exit", 0, 0, 0, 0);
        chk("lockout_exit.retries", 32'(bus.retries), 0);
        chk("lockout_exit.fault_latched", 32'(bus.fault_latched), 0);

        // Target 95, step 10, no divider, no precharge: clamps at 95.
        set_cfg(95, 10, 0, 0, 0, 1);
        bus.en = 1'b1;
        tick();
        bus.iref_target = 8'd7;   // must be ignored: config already captured
        chk("t95_pre", 32'(bus.state), 1);
        tick();
        chk_out("t95_ramp", 2, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            period();
            chk($sformatf("t95_k%0d", k), 32'(bus.iref), (10 * k > 95) ? 95 : 10 * k);
        end
        tick();
        chk_out("t95_run", 3, 1, 0, 95);
        bus.en = 1'b0;
        tick();

        // Target 250, step 15: 240 after 16 steps, then clamps to 250.
        set_cfg(250, 15, 0, 0, 0, 1);
        bus.en = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 17; k++) begin
            period();
            chk($sformatf("t250_k%0d", k), 32'(bus.iref), (15 * k > 250) ? 250 : 15 * k);
        end
        tick();
        chk_out("t250_run", 3, 1, 0, 250);
        bus.en = 1'b0;
        tick();

        // en=0 together with fault during RAMP: disable wins, no trip counted.
        set_cfg(100, 10, 1, 0, 0, 1);
        bus.en = 1'b1;
        tick();
        tick();
        chk("en_fault_ramp", 32'(bus.state), 2);
        bus.en = 1'b0;
        bus.fault = 1'b1;
        tick();
        bus.fault = 1'b0;
        chk_out("en_fault_idle", 0, 0, 0, 0);
        chk("en_fault_idle.retries", 32'(bus.retries), 0);

        // Zero step goes straight to target; then reset during RUN.
        set_cfg(50, 0, 0, 0, 0, 1);
        bus.en = 1'b1;
        tick();
        tick();
        chk_out("step0_ramp", 2, 1, 0, 0);
        tick();
        chk_out("step0_run", 3, 1, 0, 50);
        rst = 1'b1;
        tick();
        chk_out("rst_run", 0, 0, 0, 0);
        chk("rst_run.retries", 32'(bus.retries), 0);
        chk("rst_run.fault_latched", 32'(bus.fault_latched), 0);
        rst = 1'b0;
        bus.en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
